// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline constants for the ID-stage hazard controller:
// forward-select and FSM encodings, counter widths and MDU latency default.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W       = 5;
  localparam int unsigned SEL_W       = 2;
  localparam int unsigned HOLD_W      = 2;
  localparam int unsigned MDU_W       = 4;
  localparam int unsigned MDU_LAT_DEF = 4;

  typedef enum logic [SEL_W-1:0] {
    FWD_RF  = 2'b00,
    FWD_ALU = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HOLD     = 2'd1,
    ST_MDU_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic ex;
    logic mem;
    logic wb;
  } match_t;

  // Stall cycles one source needs before its operand can be forwarded.
  function automatic logic [1:0] haz_len(input match_t m, input logic ex_load,
                                         input logic mem_load);
    if (m.ex) return ex_load ? 2'd2 : 2'd1;
    if (m.mem && mem_load) return 2'd1;
    return 2'd0;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_match.sv
// Per-source dependency check: stage match flags and the ID forwarding select.
module fwd_match
  import hazard_ctrl_pkg::*;
(
  input  logic             src_use,
  input  logic [REG_W-1:0] src_reg,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_regwrite,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_regwrite,
  input  logic             mem_load,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             wb_regwrite,
  output fwd_sel_e         sel_c,
  output match_t           match_c
);

  logic live_c;

  // r0 is hardwired zero, so it never creates a dependency.
  assign live_c = src_use && (src_reg != '0);

  always_comb begin
    match_c.ex  = live_c && ex_regwrite  && (ex_dest  == src_reg);
    match_c.mem = live_c && mem_regwrite && (mem_dest == src_reg);
    match_c.wb  = live_c && wb_regwrite  && (wb_dest  == src_reg);
  end

  // A load in MEM has no data yet; the younger MEM result beats WB.
  always_comb begin
    sel_c = FWD_RF;
    if (match_c.mem && !mem_load) sel_c = FWD_ALU;
    else if (match_c.wb)          sel_c = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: operand forwarding selects, data-hazard stalls
// and multi-cycle multiply/divide occupancy.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LAT = MDU_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             id_mdu,
  input  logic [REG_W-1:0] ex_dest,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             ex_regwrite,
  input  logic             mem_regwrite,
  input  logic             wb_regwrite,
  input  logic             ex_load,
  input  logic             mem_load,
  input  logic [REG_W-1:0] wb_dest,
  output logic             stall,
  output logic             bubble,
  output logic [SEL_W-1:0] aluselectA,
  output logic [SEL_W-1:0] aluselectB,
  output logic             mdu_busy
);

  fwd_sel_e          sel_a, sel_b;
  match_t            match_a, match_b;
  logic [1:0]        len_a, len_b, hz_len;
  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [MDU_W-1:0]  mdu_q, mdu_d;
  logic              stall_c, busy_c;

  fwd_match u_fwd_a (
    .src_use     (id_use1),
    .src_reg     (id_rs1),
    .ex_dest     (ex_dest),
    .ex_regwrite (ex_regwrite),
    .mem_dest    (mem_dest),
    .mem_regwrite(mem_regwrite),
    .mem_load    (mem_load),
    .wb_dest     (wb_dest),
    .wb_regwrite (wb_regwrite),
    .sel_c       (sel_a),
    .match_c     (match_a)
  );

  fwd_match u_fwd_b (
    .src_use     (id_use2),
    .src_reg     (id_rs2),
    .ex_dest     (ex_dest),
    .ex_regwrite (ex_regwrite),
    .mem_dest    (mem_dest),
    .mem_regwrite(mem_regwrite),
    .mem_load    (mem_load),
    .wb_dest     (wb_dest),
    .wb_regwrite (wb_regwrite),
    .sel_c       (sel_b),
    .match_c     (match_b)
  );

  assign len_a  = haz_len(match_a, ex_load, mem_load);
  assign len_b  = haz_len(match_b, ex_load, mem_load);
  assign hz_len = (len_a > len_b) ? len_a : len_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      hold_q  <= '0;
      mdu_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      mdu_q   <= mdu_d;
    end
  end

  // Hazards are only evaluated in RUN; a pending hazard defers an MDU issue.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    mdu_d   = mdu_q;
    stall_c = 1'b0;
    busy_c  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (hz_len != 2'd0) begin
          stall_c = 1'b1;
          hold_d  = hz_len - 2'd1;
          state_d = (hz_len > 2'd1) ? ST_HOLD : ST_RUN;
        end else if (id_mdu) begin
          mdu_d   = MDU_W'(MDU_LAT - 1);
          state_d = ST_MDU_WAIT;
        end
      end
      ST_HOLD: begin
        stall_c = 1'b1;
        hold_d  = hold_q - 2'd1;
        if (hold_q <= 2'd1) state_d = ST_RUN;
      end
      ST_MDU_WAIT: begin
        stall_c = 1'b1;
        busy_c  = 1'b1;
        mdu_d   = mdu_q - 4'd1;
        if (mdu_q <= 4'd1) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Reset forces quiet outputs even while hazard-looking inputs are present.
  assign stall      = stall_c & rst_n;
  assign bubble     = stall_c & rst_n;
  assign mdu_busy   = busy_c & rst_n;
  assign aluselectA = rst_n ? sel_a : FWD_RF;
  assign aluselectB = rst_n ? sel_b : FWD_RF;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed pipeline scenarios followed by
// randomized inputs checked against a cycle-count reference model.
module tb_hazard_ctrl;

  localparam int unsigned MDU_LAT = 4;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs1, rs2;
    logic       use1, use2, mdu;
    logic [4:0] ex_dest, mem_dest, wb_dest;
    logic       ex_rw, mem_rw, wb_rw, ex_load, mem_load;
  } stim_t;

  typedef struct packed {
    logic       stall;
    logic       bubble;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       busy;
  } exp_t;

  logic       clk, rst_n;
  logic [4:0] id_rs1, id_rs2, ex_dest, mem_dest, wb_dest;
  logic       id_use1, id_use2, id_mdu;
  logic       ex_regwrite, mem_regwrite, wb_regwrite, ex_load, mem_load;
  logic       stall, bubble, mdu_busy;
  logic [1:0] aluselectA, aluselectB;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_no  = 0;
  exp_t  exp_q[$];
  string tag_q[$];

  // Reference model state: outstanding stall and MDU cycles.
  int stall_left = 0;
  int mdu_left   = 0;

  hazard_ctrl #(.MDU_LAT(MDU_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use1     (id_use1),
    .id_use2     (id_use2),
    .id_mdu      (id_mdu),
    .ex_dest     (ex_dest),
    .mem_dest    (mem_dest),
    .ex_regwrite (ex_regwrite),
    .mem_regwrite(mem_regwrite),
    .wb_regwrite (wb_regwrite),
    .ex_load     (ex_load),
    .mem_load    (mem_load),
    .wb_dest     (wb_dest),
    .stall       (stall),
    .bubble      (bubble),
    .aluselectA  (aluselectA),
    .aluselectB  (aluselectB),
    .mdu_busy    (mdu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit hit(input bit u, input logic [4:0] r, input bit rw,
                             input logic [4:0] d);
    return u && (r != 5'd0) && rw && (d == r);
  endfunction

  function automatic logic [1:0] ref_sel(input bit u, input logic [4:0] r, input stim_t s);
    if (hit(u, r, s.mem_rw, s.mem_dest) && !s.mem_load) return 2'b01;
    if (hit(u, r, s.wb_rw, s.wb_dest)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int ref_need(input bit u, input logic [4:0] r, input stim_t s);
    if (hit(u, r, s.ex_rw, s.ex_dest)) return s.ex_load ? 2 : 1;
    if (hit(u, r, s.mem_rw, s.mem_dest) && s.mem_load) return 1;
    return 0;
  endfunction

  function automatic exp_t mk(input bit st, input logic [1:0] sa, input logic [1:0] sb,
                              input bit busy);
    exp_t e;
    e.stall = st; e.bubble = st; e.sa = sa; e.sb = sb; e.busy = busy;
    return e;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  // Advances the model by one cycle and returns its expected outputs.
  function automatic exp_t model_step(input stim_t s);
    exp_t e;
    int   n;
    e = '0;
    if (!s.rst_n) begin
      stall_left = 0;
      mdu_left   = 0;
      return e;
    end
    e.sa = ref_sel(s.use1, s.rs1, s);
    e.sb = ref_sel(s.use2, s.rs2, s);
    if (mdu_left > 0) begin
      e.stall = 1'b1; e.busy = 1'b1; mdu_left--;
    end else if (stall_left > 0) begin
      e.stall = 1'b1; stall_left--;
    end else begin
      n = ref_need(s.use1, s.rs1, s);
      if (ref_need(s.use2, s.rs2, s) > n) n = ref_need(s.use2, s.rs2, s);
      if (n > 0) begin
        e.stall = 1'b1; stall_left = n - 1;
      end else if (s.mdu) begin
        mdu_left = int'(MDU_LAT) - 1;
      end
    end
    e.bubble = e.stall;
    return e;
  endfunction

  task automatic cyc(input stim_t s, input bit directed, input exp_t de, input string tag);
    exp_t m;
    rst_n = s.rst_n; id_rs1 = s.rs1; id_rs2 = s.rs2; id_use1 = s.use1; id_use2 = s.use2;
    id_mdu = s.mdu; ex_dest = s.ex_dest; mem_dest = s.mem_dest; wb_dest = s.wb_dest;
    ex_regwrite = s.ex_rw; mem_regwrite = s.mem_rw; wb_regwrite = s.wb_rw;
    ex_load = s.ex_load; mem_load = s.mem_load;
    m = model_step(s);
    exp_q.push_back(directed ? de : m);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  function automatic void check(input string name, input string field,
                                input logic [1:0] act, input logic [1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s cycle %0d: got %0b expected %0b", name, field, cyc_no, act, req);
    end
  endfunction

  // Monitor: one expected response per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, "stall",      {1'b0, stall},    {1'b0, e.stall});
      check(t, "bubble",     {1'b0, bubble},   {1'b0, e.bubble});
      check(t, "aluselectA", aluselectA,       e.sa);
      check(t, "aluselectB", aluselectB,       e.sb);
      check(t, "mdu_busy",   {1'b0, mdu_busy}, {1'b0, e.busy});
      cyc_no++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    rst_n = 1'b0;
    @(posedge clk);
    #1;

    // Reset with hazard-looking inputs: everything quiet.
    s = idle(); s.rst_n = 1'b0; s.ex_dest = 5; s.ex_rw = 1; s.rs1 = 5; s.use1 = 1;
    s.wb_dest = 5; s.wb_rw = 1; s.mdu = 1;
    cyc(s, 1, mk(0, 2'b00, 2'b00, 0), "reset");
    cyc(s, 1, mk(0, 2'b00, 2'b00, 0), "reset");

    // ALU-to-use: one stall, then forward from EX/MEM.
    s = idle(); s.ex_dest = 5; s.ex_rw = 1; s.rs1 = 5; s.use1 = 1;
    cyc(s, 1, mk(1, 2'b00, 2'b00, 0), "alu_use_stall");
    s = idle(); s.mem_dest = 5; s.mem_rw = 1; s.rs1 = 5; s.use1 = 1;
    cyc(s, 1, mk(0, 2'b01, 2'b00, 0), "alu_use_fwd");

    // Load-to-use: two stalls, then forward from MEM/WB.
    s = idle(); s.ex_dest = 7; s.ex_rw = 1; s.ex_load = 1; s.rs2 = 7; s.use2 = 1;
    cyc(s, 1, mk(1, 2'b00, 2'b00, 0), "load_use_1");
    s = idle(); s.mem_dest = 7; s.mem_rw = 1; s.mem_load = 1; s.rs2 = 7; s.use2 = 1;
    cyc(s, 1, mk(1, 2'b00, 2'b00, 0), "load_use_2");
    s = idle(); s.wb_dest = 7; s.wb_rw = 1; s.rs2 = 7; s.use2 = 1;
    cyc(s, 1, mk(0, 2'b00, 2'b10, 0), "load_use_fwd");

    // r0 never matches.
    s = idle(); s.ex_dest = 0; s.ex_rw = 1; s.mem_dest = 0; s.mem_rw = 1;
    s.use1 = 1; s.use2 = 1;
    cyc(s, 1, mk(0, 2'b00, 2'b00, 0), "r0_write");

    // MEM non-load beats WB on both sources.
    s = idle(); s.mem_dest = 3; s.mem_rw = 1; s.wb_dest = 3; s.wb_rw = 1;
    s.rs1 = 3; s.rs2 = 3; s.use1 = 1; s.use2 = 1;
    cyc(s, 1, mk(0, 2'b01, 2'b01, 0), "mem_wins");

    // Unused source ignores a matching load in EX.
    s = idle(); s.ex_dest = 4; s.ex_rw = 1; s.ex_load = 1; s.rs1 = 4;
    cyc(s, 1, mk(0, 2'b00, 2'b00, 0), "no_use");

    // Load in MEM with an older WB write to the same register.
    s = idle(); s.mem_dest = 6; s.mem_rw = 1; s.mem_load = 1; s.wb_dest = 6; s.wb_rw = 1;
    s.rs1 = 6; s.use1 = 1;
    cyc(s, 1, mk(1, 2'b10, 2'b00, 0), "mem_load_stall");
    s = idle(); s.wb_dest = 6; s.wb_rw = 1; s.rs1 = 6; s.use1 = 1;
    cyc(s, 1, mk(0, 2'b10, 2'b00, 0), "mem_load_fwd");

    // Hazard defers the MDU issue; selects stay live during MDU_WAIT.
    s = idle(); s.ex_dest = 5; s.ex_rw = 1; s.rs1 = 5; s.use1 = 1; s.mdu = 1;
    cyc(s, 1, mk(1, 2'b00, 2'b00, 0), "haz_before_mdu");
    s = idle(); s.mem_dest = 5; s.mem_rw = 1; s.rs1 = 5; s.use1 = 1; s.mdu = 1;
    cyc(s, 1, mk(0, 2'b01, 2'b00, 0), "mdu_issue");
    s = idle(); s.mdu = 1;
    cyc(s, 1, mk(1, 2'b00, 2'b00, 1), "mdu_wait1");
    s.mem_dest = 2; s.mem_rw = 1; s.rs2 = 2; s.use2 = 1;
    cyc(s, 1, mk(1, 2'b00, 2'b01, 1), "mdu_wait2");
    s = idle(); s.mdu = 1;
    cyc(s, 1, mk(1, 2'b00, 2'b00, 1), "mdu_wait3");
    s = idle();
    cyc(s, 1, mk(0, 2'b00, 2'b00, 0), "mdu_done");

    // Reset in the middle of MDU_WAIT aborts it.
    s = idle(); s.mdu = 1;
    cyc(s, 1, mk(0, 2'b00, 2'b00, 0), "mdu_issue2");
    cyc(s, 1, mk(1, 2'b00, 2'b00, 1), "mdu_wait_b");
    s.rst_n = 1'b0;
    cyc(s, 1, mk(0, 2'b00, 2'b00, 0), "mdu_reset");
    s = idle();
    cyc(s, 1, mk(0, 2'b00, 2'b00, 0), "mdu_after_rst");

    // Reset on the second cycle of a load-use stall.
    s = idle(); s.ex_dest = 7; s.ex_rw = 1; s.ex_load = 1; s.rs2 = 7; s.use2 = 1;
    cyc(s, 1, mk(1, 2'b00, 2'b00, 0), "lu_rst_1");
    s.rst_n = 1'b0;
    cyc(s, 1, mk(0, 2'b00, 2'b00, 0), "lu_rst_2");
    s = idle();
    cyc(s, 1, mk(0, 2'b00, 2'b00, 0), "lu_after_rst1");
    cyc(s, 1, mk(0, 2'b00, 2'b00, 0), "lu_after_rst2");

    // Randomized traffic over a small register set to make hazards frequent.
    for (int i = 0; i < 400; i++) begin
      s.rst_n    = ($urandom_range(0, 39) != 0);
      s.rs1      = 5'($urandom_range(0, 3));
      s.rs2      = 5'($urandom_range(0, 3));
      s.use1     = 1'($urandom);
      s.use2     = 1'($urandom);
      s.mdu      = ($urandom_range(0, 3) == 0);
      s.ex_dest  = 5'($urandom_range(0, 3));
      s.mem_dest = 5'($urandom_range(0, 3));
      s.wb_dest  = 5'($urandom_range(0, 3));
      s.ex_rw    = 1'($urandom);
      s.mem_rw   = 1'($urandom);
      s.wb_rw    = 1'($urandom);
      s.ex_load  = 1'($urandom);
      s.mem_load = 1'($urandom);
      cyc(s, 0, '0, "random");
    end

    s = idle();
    cyc(s, 0, '0, "drain");
    cyc(s, 0, '0, "drain");
    @(negedge clk);
    #1;

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
